// File: rtl/runner_engine.sv
// rtl/runner_engine.sv - game-state engine: scrolling obstacle field, player row, score, game-over
// Every output is a register; one scroll step per TICK_DIV clocks while running.
module runner_engine #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loggedIn,
  input  logic        start,
  input  logic        flipBtn,
  output logic [5:0]  ceilingBits,
  output logic [5:0]  floorBits,
  output logic        playerPos,
  output logic [13:0] score,
  output logic        showScore
);

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [13:0]   SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_start_q, r_flip_q;
  logic [CW-1:0] r_tick, w_tick_nxt;
  logic [7:0]    r_lfsr, w_lfsr_nxt;
  logic [5:0]    r_ceil, r_floor, w_ceil_nxt, w_floor_nxt;
  logic          r_pos, w_pos_nxt;
  logic [13:0]   r_score, w_score_nxt;
  logic          r_show, w_show_nxt;

  logic w_start_edge, w_flip_edge, w_collide, w_fb;
  logic w_step, w_new_c, w_new_f;

  assign w_start_edge = start & ~r_start_q;
  assign w_flip_edge  = flipBtn & ~r_flip_q;
  assign w_collide    = r_pos ? ~r_ceil[4] : ~r_floor[4];
  assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // A column right behind an obstacle is always empty, so the player can always escape.
  always_comb begin
    w_new_c = 1'b1;
    w_new_f = 1'b1;
    if (r_ceil[0] && r_floor[0]) begin
      unique case (r_lfsr[1:0])
        2'b00:   w_new_f = 1'b0;
        2'b01:   w_new_c = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_lfsr_nxt  = r_lfsr;
    w_ceil_nxt  = r_ceil;
    w_floor_nxt = r_floor;
    w_pos_nxt   = r_pos;
    w_score_nxt = r_score;
    w_show_nxt  = r_show;
    w_step      = 1'b0;
    if (!loggedIn) begin
      w_state_nxt = S_IDLE;
      w_tick_nxt  = '0;
      w_ceil_nxt  = 6'h3F;
      w_floor_nxt = 6'h3F;
      w_pos_nxt   = 1'b0;
      w_score_nxt = '0;
      w_show_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            w_state_nxt = S_RUN;
            w_tick_nxt  = '0;
          end
        end
        S_RUN: begin
          if (w_collide) begin
            w_state_nxt = S_OVER;
            w_show_nxt  = 1'b1;
          end else begin
            if (w_flip_edge) w_pos_nxt = ~r_pos;
            if (r_tick == TICK_LAST) begin
              w_tick_nxt = '0;
              w_step     = 1'b1;
            end else begin
              w_tick_nxt = r_tick + CW'(1);
            end
          end
        end
        S_OVER: begin
          if (w_start_edge) begin
            w_state_nxt = S_RUN;
            w_tick_nxt  = '0;
            w_ceil_nxt  = 6'h3F;
            w_floor_nxt = 6'h3F;
            w_pos_nxt   = 1'b0;
            w_score_nxt = '0;
            w_show_nxt  = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_step) begin
        w_ceil_nxt  = {r_ceil[4:0], w_new_c};
        w_floor_nxt = {r_floor[4:0], w_new_f};
        w_lfsr_nxt  = {r_lfsr[6:0], w_fb};
        if (r_score < SCORE_MAX) w_score_nxt = r_score + 14'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_flip_q  <= 1'b0;
      r_tick    <= '0;
      r_lfsr    <= LFSR_SEED;
      r_ceil    <= 6'h3F;
      r_floor   <= 6'h3F;
      r_pos     <= 1'b0;
      r_score   <= '0;
      r_show    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_flip_q  <= flipBtn;
      r_tick    <= w_tick_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_ceil    <= w_ceil_nxt;
      r_floor   <= w_floor_nxt;
      r_pos     <= w_pos_nxt;
      r_score   <= w_score_nxt;
      r_show    <= w_show_nxt;
    end
  end

  assign ceilingBits = r_ceil;
  assign floorBits   = r_floor;
  assign playerPos   = r_pos;
  assign score       = r_score;
  assign showScore   = r_show;

endmodule

// File: doc/runner_engine.md
# runner_engine

Game-state engine for the segment-runner display path. Owns the scrolling obstacle field, the player's floor/ceiling position, the run score and the game-over flag. Drives the obstacle, player, score and score-view inputs of the 7-segment display decoder. All outputs are registered.

## Interface
- TICK_DIV, 25_000_000, clock cycles per scroll step; legal range is 1 and up.
- LFSR_SEED, 8'hA5, reset value of the obstacle LFSR; must be nonzero.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- loggedIn  in  1  user session active; low forces IDLE
- start  in  1  start button, level; a rising edge is the request
- flipBtn  in  1  flip button, level; a rising edge is the request
- ceilingBits  out  6  ceiling row, active-low (0 = obstacle); bit 5 is the leftmost column
- floorBits  out  6  floor row, active-low; bit 5 is the leftmost column
- playerPos  out  1  0 = floor, 1 = ceiling; the player occupies column 4
- score  out  14  steps survived, binary, range 0..9999
- showScore  out  1  1 = game over, score view selected

## Operation
- **Edge detect:** registers `start_q` and `flip_q` reset to 0. `startEdge = start & ~start_q`. `flipEdge = flipBtn & ~flip_q`.
- **Reset values:**
  - state = IDLE
  - ceilingBits = 6'h3F, floorBits = 6'h3F
  - playerPos = 0, score = 0, showScore = 0
  - tick counter = 0, LFSR = LFSR_SEED
- **Priority:** rst, then `!loggedIn`, then the state logic below.
- **loggedIn low (any state):** next cycle go to IDLE. Clear the field to 6'h3F, and clear playerPos, score, showScore and the tick counter. The LFSR keeps its value.
- **IDLE:** outputs hold their cleared values. On startEdge, go to RUN, with the tick counter at 0.
- **RUN, collision check:** every cycle, evaluate collision on the registered values: `(playerPos==0 && floorBits[4]==0) || (playerPos==1 && ceilingBits[4]==0)`.
- **RUN, collision cycle:** go to OVER and set showScore = 1. No step, no flip and no score change in that cycle.
- **RUN, flip:** otherwise, a flipEdge toggles playerPos.
- **RUN, tick counter:** otherwise, the counter increments. When it equals TICK_DIV-1, it wraps to 0 and a step occurs.
- **Step:**
  - `ceilingBits <= {ceilingBits[4:0], newC}`, `floorBits <= {floorBits[4:0], newF}`.
  - Advance the LFSR one shift: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  - If score < 9999, score increments; otherwise it saturates.
  - A flip and a step in the same cycle are both applied. Collision is then checked on the next cycle.
- **New column (from the pre-shift LFSR[1:0]):**
  - If `ceilingBits[0]==0` or `floorBits[0]==0`, the new column is empty: newC = newF = 1. This keeps a guaranteed gap after every obstacle.
  - Else 2'b00: floor obstacle (newF = 0, newC = 1).
  - Else 2'b01: ceiling obstacle (newC = 0, newF = 1).
  - Else: empty.
  - Never both rows in one column.
- **OVER:** field, playerPos and score are frozen, and showScore = 1.
  - On startEdge, go to RUN in the next cycle: field = 6'h3F, playerPos = 0, score = 0, showScore = 0, tick counter = 0.
  - flipEdge is ignored.

## Timing
- All outputs update on the clk rising edge. No output is combinational.
- IDLE to RUN takes 1 cycle after the startEdge cycle. The first step lands TICK_DIV cycles after RUN is entered.
- Collision to showScore = 1 takes 1 cycle.
- A flip appears on playerPos 1 cycle after the edge cycle.
- Reset asserted mid-game returns every output to its reset value on the next edge.
- With TICK_DIV = 1, a step occurs every RUN cycle that is not a collision cycle.

## Test plan
- **Reset:** assert rst for 2 cycles -> ceilingBits = floorBits = 6'h3F, playerPos = 0, score = 0, showScore = 0.
- **Start gating:** with TICK_DIV = 4, start pulsed while loggedIn = 0 -> stays IDLE with score 0. With loggedIn = 1 -> score = 1 exactly 5 cycles after the start edge, and 2 four cycles later.
- **Flip edge:** hold flipBtn high for 10 cycles during RUN -> playerPos toggles exactly once. Release and press again -> toggles back.
- **Collision:** with TICK_DIV = 1, leave the player on the floor until floorBits[4] = 0 -> showScore = 1 on the next cycle. Score equals the number of steps taken and stays frozen for 20 more cycles. A start edge then gives score 0, field 6'h3F and showScore 0.
- **Score saturation:** with TICK_DIV = 1, the bench flips to the clear row whenever column 3 holds an obstacle on the player's row. After 10,050 steps -> score = 9999 and holds. Every step the bench checks that no column has both bits 0 and that no two adjacent columns both hold an obstacle.
- **Logout mid-run:** drop loggedIn at score 37 -> next cycle score = 0, field 6'h3F, showScore = 0, IDLE. A start edge with loggedIn = 1 restarts the game.
